// File: rtl/la_iolib_pkg.sv
// Shared IO-library definitions: sequencer state encoding and a width helper.
package la_iolib_pkg;

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_RAMP    = 3'd1,
        ST_WAIT_PG = 3'd2,
        ST_ON      = 3'd3,
        ST_DOWN    = 3'd4,
        ST_FAULT   = 3'd5
    } seq_state_e;

    // ceil(log2(n)) with a floor of one bit, so a one-segment ring still has an index
    function automatic int LA_CLOG2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/la_iopwrseq_timer.sv
// Loadable down-counter shared by the ramp, power-good and power-down waits.
module la_iopwrseq_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] val,
    output logic          zero
);

    logic [CW-1:0] cnt;

    // load takes priority; otherwise count down and hold at zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/la_iopwrseq.sv
// IO-ring supply sequencer: ordered power-up with power-good checks,
// reverse-order power-down, and a sticky safe state on supply failure.
module la_iopwrseq
    import la_iolib_pkg::*;
#(
    parameter int NSEG = 4,
    parameter int CW   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr,
    input  logic [CW-1:0]             ramp_cycles,
    input  logic [CW-1:0]             pg_timeout,
    input  logic [NSEG-1:0]           pg,
    output logic [NSEG-1:0]           seg_en,
    output logic                      iso,
    output logic                      ready,
    output logic                      busy,
    output logic                      fault,
    output logic [LA_CLOG2(NSEG)-1:0] fault_seg
);

    localparam int             FSW  = LA_CLOG2(NSEG);
    localparam logic [FSW-1:0] LAST = FSW'(NSEG - 1);

    seq_state_e     state, state_n;
    logic [FSW-1:0] idx, idx_n, idx_inc, low0, fault_seg_n;
    logic [CW-1:0]  r_lat, r_lat_n, t_lat, t_lat_n, tval, down_wait;
    logic [NSEG-1:0] seg_en_n;
    logic           tload, tzero;

    assign idx_inc = idx + 1'b1;
    // a zero ramp still spaces power-down clears by one cycle
    assign down_wait = (r_lat == '0) ? '0 : r_lat - 1'b1;

    // lowest segment whose power-good is currently low
    always_comb begin
        low0 = '0;
        for (int k = NSEG - 1; k >= 0; k--) begin
            if (!pg[k]) low0 = FSW'(k);
        end
    end

    la_iopwrseq_timer #(.CW(CW)) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (tload),
        .val  (tval),
        .zero (tzero)
    );

    // next-state, segment-enable and timer-load decisions
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        r_lat_n     = r_lat;
        t_lat_n     = t_lat;
        seg_en_n    = seg_en;
        fault_seg_n = fault_seg;
        tload       = 1'b0;
        tval        = '0;
        case (state)
            ST_OFF: begin
                if (en) begin
                    r_lat_n  = ramp_cycles;
                    t_lat_n  = pg_timeout;
                    seg_en_n = NSEG'(1);
                    idx_n    = '0;
                    tload    = 1'b1;
                    if (ramp_cycles == '0) begin
                        state_n = ST_WAIT_PG;
                        tval    = pg_timeout;
                    end else begin
                        state_n = ST_RAMP;
                        tval    = ramp_cycles - 1'b1;
                    end
                end
            end
            ST_RAMP: begin
                if (!en) begin
                    state_n = ST_DOWN;
                    tload   = 1'b1;
                end else if (tzero) begin
                    state_n = ST_WAIT_PG;
                    tload   = 1'b1;
                    tval    = t_lat;
                end
            end
            ST_WAIT_PG: begin
                if (pg[idx] && en) begin
                    if (idx == LAST) begin
                        state_n = ST_ON;
                    end else begin
                        seg_en_n[idx_inc] = 1'b1;
                        idx_n             = idx_inc;
                        tload             = 1'b1;
                        if (r_lat == '0) begin
                            tval = t_lat;
                        end else begin
                            state_n = ST_RAMP;
                            tval    = r_lat - 1'b1;
                        end
                    end
                end else if (!pg[idx] && tzero) begin
                    state_n     = ST_FAULT;
                    fault_seg_n = idx;
                end else if (!en) begin
                    state_n = ST_DOWN;
                    tload   = 1'b1;
                end
            end
            ST_ON: begin
                if (pg != '1) begin
                    state_n     = ST_FAULT;
                    fault_seg_n = low0;
                end else if (!en) begin
                    state_n = ST_DOWN;
                    tload   = 1'b1;
                end
            end
            ST_DOWN: begin
                if (tzero) begin
                    if (seg_en == '0) begin
                        state_n = ST_OFF;
                    end else begin
                        seg_en_n[idx] = 1'b0;
                        if (idx != '0) idx_n = idx - 1'b1;
                        tload = 1'b1;
                        tval  = down_wait;
                    end
                end
            end
            ST_FAULT: begin
                if (clr && !en) state_n = ST_OFF;
            end
            default: state_n = ST_OFF;
        endcase
        if (state_n == ST_FAULT) seg_en_n = '0;
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_OFF;
            idx       <= '0;
            r_lat     <= '0;
            t_lat     <= '0;
            seg_en    <= '0;
            iso       <= 1'b1;
            ready     <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            fault_seg <= '0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            r_lat     <= r_lat_n;
            t_lat     <= t_lat_n;
            seg_en    <= seg_en_n;
            iso       <= (state_n != ST_ON);
            ready     <= (state_n == ST_ON);
            busy      <= (state_n == ST_RAMP) || (state_n == ST_WAIT_PG) || (state_n == ST_DOWN);
            fault     <= (state_n == ST_FAULT);
            fault_seg <= fault_seg_n;
        end
    end

endmodule

// File: tb/tb_la_iopwrseq.sv
// Bench for la_iopwrseq: directed scenarios then random traffic, all checked
// against a deadline-based reference model through an expected-output queue.
module tb_la_iopwrseq;

    localparam int NSEG = 4;
    localparam int CW   = 8;
    localparam int FSW  = 2;

    localparam int M_OFF = 0, M_RAMP = 1, M_WAIT = 2, M_ON = 3, M_DOWN = 4, M_FAULT = 5;

    logic            clk = 1'b0;
    logic            reset, en, clr;
    logic [CW-1:0]   ramp_cycles, pg_timeout;
    logic [NSEG-1:0] pg;
    logic [NSEG-1:0] seg_en;
    logic            iso, ready, busy, fault;
    logic [FSW-1:0]  fault_seg;

    typedef struct packed {
        logic [NSEG-1:0] seg_en;
        logic            iso;
        logic            ready;
        logic            busy;
        logic            fault;
        logic [FSW-1:0]  fseg;
    } exp_t;

    exp_t q[$];
    exp_t mx, gx;
    int   ntests = 0;
    int   nfail  = 0;

    // reference model: phase, segments on, and absolute deadline edge
    int ph = M_OFF, n_on = 0, seg = 0, rl = 0, tl = 0, dl = 0, fs = 0, e = 0;
    // stimulus knobs
    int rc_g = 0, pt_g = 0, rise_pct = 100, dead = -1, drop = -1;
    logic [NSEG-1:0] pg_v = '0;

    always #5 clk = ~clk;

    la_iopwrseq #(.NSEG(NSEG), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .clr        (clr),
        .ramp_cycles(ramp_cycles),
        .pg_timeout (pg_timeout),
        .pg         (pg),
        .seg_en     (seg_en),
        .iso        (iso),
        .ready      (ready),
        .busy       (busy),
        .fault      (fault),
        .fault_seg  (fault_seg)
    );

    function automatic exp_t model_out();
        exp_t x;
        x.seg_en = (ph == M_FAULT) ? '0 : NSEG'((1 << n_on) - 1);
        x.iso    = (ph != M_ON);
        x.ready  = (ph == M_ON);
        x.busy   = (ph == M_RAMP) || (ph == M_WAIT) || (ph == M_DOWN);
        x.fault  = (ph == M_FAULT);
        x.fseg   = FSW'(fs);
        return x;
    endfunction

    // a newly switched segment settles for rl cycles, then waits tl+1 cycles for power-good
    task automatic start_seg();
        if (rl == 0) begin
            ph = M_WAIT;
            dl = e + 1 + tl;
        end else begin
            ph = M_RAMP;
            dl = e + rl;
        end
    endtask

    task automatic model_step(input logic rs, input logic en_i, input logic clr_i,
                              input logic [NSEG-1:0] pg_i);
        if (rs) begin
            ph = M_OFF; n_on = 0; seg = 0; fs = 0;
        end else begin
            case (ph)
                M_OFF: if (en_i) begin
                    rl = rc_g; tl = pt_g; n_on = 1; seg = 0;
                    start_seg();
                end
                M_RAMP: begin
                    if (!en_i) begin ph = M_DOWN; dl = e + 1; end
                    else if (e == dl) begin ph = M_WAIT; dl = e + 1 + tl; end
                end
                M_WAIT: begin
                    if (pg_i[seg] && en_i) begin
                        if (seg == NSEG - 1) ph = M_ON;
                        else begin seg++; n_on++; start_seg(); end
                    end else if (!pg_i[seg] && e == dl) begin
                        ph = M_FAULT; fs = seg; n_on = 0;
                    end else if (!en_i) begin
                        ph = M_DOWN; dl = e + 1;
                    end
                end
                M_ON: begin
                    if (pg_i != '1) begin
                        ph = M_FAULT; n_on = 0;
                        for (int k = NSEG - 1; k >= 0; k--) if (!pg_i[k]) fs = k;
                    end else if (!en_i) begin
                        ph = M_DOWN; dl = e + 1;
                    end
                end
                M_DOWN: if (e == dl) begin
                    if (n_on == 0) ph = M_OFF;
                    else begin n_on--; dl = e + ((rl > 0) ? rl : 1); end
                end
                default: if (clr_i && !en_i) ph = M_OFF;
            endcase
        end
        e++;
    endtask

    task automatic drive_cycle(input logic rs, input logic en_i, input logic clr_i);
        @(negedge clk);
        for (int k = 0; k < NSEG; k++) begin
            if (ph == M_FAULT || k >= n_on || k == drop) pg_v[k] = 1'b0;
            else if (!pg_v[k] && k != dead && $urandom_range(0, 99) < rise_pct) pg_v[k] = 1'b1;
        end
        reset       = rs;
        en          = en_i;
        clr         = clr_i;
        ramp_cycles = CW'(rc_g);
        pg_timeout  = CW'(pt_g);
        pg          = pg_v;
        model_step(rs, en_i, clr_i, pg_v);
        q.push_back(model_out());
    endtask

    task automatic run(input int n, input logic rs, input logic en_i, input logic clr_i);
        for (int c = 0; c < n; c++) drive_cycle(rs, en_i, clr_i);
    endtask

    // monitor: one registered output bundle per cycle, compared against the queue head
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mx = q.pop_front();
            gx = '{seg_en, iso, ready, busy, fault, fault_seg};
            ntests++;
            if (gx !== mx) begin
                nfail++;
                $display("FAIL outputs t=%0t got seg_en=%b iso=%b ready=%b busy=%b fault=%b fseg=%0d exp seg_en=%b iso=%b ready=%b busy=%b fault=%b fseg=%0d",
                         $time, gx.seg_en, gx.iso, gx.ready, gx.busy, gx.fault, gx.fseg,
                         mx.seg_en, mx.iso, mx.ready, mx.busy, mx.fault, mx.fseg);
            end
        end
    end

    initial begin
        reset = 1'b1; en = 1'b0; clr = 1'b0; pg = '0;
        ramp_cycles = '0; pg_timeout = '0;

        // reset, then full power-up with pg following seg_en, then power-down
        run(3, 1'b1, 1'b0, 1'b0);
        rc_g = 3; pt_g = 5; rise_pct = 100;
        run(25, 1'b0, 1'b1, 1'b0);
        run(20, 1'b0, 1'b0, 1'b0);
        // power-good timeout on segment 1, clr ignored while en=1, then cleared
        rc_g = 2; pt_g = 4; dead = 1;
        run(20, 1'b0, 1'b1, 1'b0);
        run(2, 1'b0, 1'b1, 1'b1);
        run(2, 1'b0, 1'b0, 1'b0);
        run(1, 1'b0, 1'b0, 1'b1);
        run(3, 1'b0, 1'b0, 1'b0);
        // abort during ramp of segment 1
        dead = -1; rc_g = 3; pt_g = 5;
        run(6, 1'b0, 1'b1, 1'b0);
        run(15, 1'b0, 1'b0, 1'b0);
        // brown-out on segment 2 while on
        run(25, 1'b0, 1'b1, 1'b0);
        drop = 2;
        run(3, 1'b0, 1'b1, 1'b0);
        drop = -1;
        run(1, 1'b0, 1'b0, 1'b1);
        run(2, 1'b0, 1'b0, 1'b0);
        // zero ramp: one segment per cycle, up and down
        rc_g = 0; pt_g = 3;
        run(8, 1'b0, 1'b1, 1'b0);
        run(8, 1'b0, 1'b0, 1'b0);
        // reset while waiting for power-good
        rc_g = 1; pt_g = 10; dead = 0;
        run(4, 1'b0, 1'b1, 1'b0);
        run(1, 1'b1, 1'b1, 1'b0);
        dead = -1;
        run(2, 1'b0, 1'b0, 1'b0);

        // random traffic
        begin
            logic en_r, clr_r, rs_r;
            en_r = 1'b0;
            for (int c = 0; c < 4000; c++) begin
                if (en_r) begin
                    if ($urandom_range(0, 59) == 0) en_r = 1'b0;
                end else if ($urandom_range(0, 9) == 0) begin
                    en_r = 1'b1;
                end
                clr_r = ($urandom_range(0, 5) == 0);
                rs_r  = ($urandom_range(0, 299) == 0);
                rc_g  = $urandom_range(0, 4);
                pt_g  = $urandom_range(0, 6);
                if (ph == M_OFF) begin
                    rise_pct = $urandom_range(30, 100);
                    dead     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, NSEG - 1) : -1;
                end
                drop = (ph == M_ON && $urandom_range(0, 149) == 0) ? $urandom_range(0, NSEG - 1) : -1;
                drive_cycle(rs_r, en_r, clr_r);
            end
        end
        drop = -1;

        repeat (3) @(posedge clk);
        #2;
        ntests++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL drain got %0d pending entries, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
